// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports with
// write-to-read bypass, optional hardwired zero register and a clear-sweep sequencer.
module reg_file_param #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_ready,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]   rd2_q, rd2_d;
    logic                    wr_acc_s;
    logic                    wr_commit_s;
    logic                    zero_wr_s;

    assign write_ready = (state_q != ST_CLEAR);
    assign clear_busy  = (state_q == ST_CLEAR);
    assign clear_done  = (state_q == ST_DONE);
    assign read_data_1 = rd1_q;
    assign read_data_2 = rd2_q;

    assign wr_acc_s    = reg_write && write_ready;
    assign zero_wr_s   = (ZERO_REG != 0) && (write_reg == '0);
    assign wr_commit_s = wr_acc_s && !zero_wr_s;

    // Sweep sequencer next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Read port 1 priority: zero register, sweep target, bypass, array
    always_comb begin
        rd1_d = regs_q[read_reg_1];
        if ((ZERO_REG != 0) && (read_reg_1 == '0)) begin
            rd1_d = '0;
        end else if (clear_busy && (read_reg_1 == idx_q)) begin
            rd1_d = '0;
        end else if (wr_acc_s && (write_reg == read_reg_1)) begin
            rd1_d = write_data;
        end else begin
            rd1_d = regs_q[read_reg_1];
        end
    end

    // Read port 2 priority: zero register, sweep target, bypass, array
    always_comb begin
        rd2_d = regs_q[read_reg_2];
        if ((ZERO_REG != 0) && (read_reg_2 == '0)) begin
            rd2_d = '0;
        end else if (clear_busy && (read_reg_2 == idx_q)) begin
            rd2_d = '0;
        end else if (wr_acc_s && (write_reg == read_reg_2)) begin
            rd2_d = write_data;
        end else begin
            rd2_d = regs_q[read_reg_2];
        end
    end

    // Sequencer state, sweep index and read output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    // Register array: sweep zeroing and write commit never coincide
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clear_busy) begin
            regs_q[idx_q] <= '0;
        end else if (wr_commit_s) begin
            regs_q[write_reg] <= write_data;
        end else begin
            regs_q[write_reg] <= regs_q[write_reg];
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 24/2/1 instance plus a 32/5/0 variant.
module tb_reg_file_param;

    logic clk;
    logic reset_n;

    logic        a_we, a_cs, a_ready, a_busy, a_done;
    logic [1:0]  a_wa, a_r1, a_r2;
    logic [23:0] a_wd, a_rd1, a_rd2;

    logic        b_we, b_cs, b_ready, b_busy, b_done;
    logic [4:0]  b_wa, b_r1, b_r2;
    logic [31:0] b_wd, b_rd1, b_rd2;

    int checks = 0;
    int errors = 0;
    int n;

    reg_file_param #(.DATA_WIDTH(24), .ADDR_WIDTH(2), .ZERO_REG(1)) dut_a (
        .clock(clk), .reset_n(reset_n), .reg_write(a_we), .write_reg(a_wa),
        .write_data(a_wd), .write_ready(a_ready), .read_reg_1(a_r1), .read_reg_2(a_r2),
        .read_data_1(a_rd1), .read_data_2(a_rd2), .clear_start(a_cs),
        .clear_busy(a_busy), .clear_done(a_done)
    );

    reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_b (
        .clock(clk), .reset_n(reset_n), .reg_write(b_we), .write_reg(b_wa),
        .write_data(b_wd), .write_ready(b_ready), .read_reg_1(b_r1), .read_reg_2(b_r2),
        .read_data_1(b_rd1), .read_data_2(b_rd2), .clear_start(b_cs),
        .clear_busy(b_busy), .clear_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_flags(input string tag, input logic busy, input logic ready, input logic done);
        chk({tag, "_busy"},  {31'd0, a_busy},  {31'd0, busy});
        chk({tag, "_ready"}, {31'd0, a_ready}, {31'd0, ready});
        chk({tag, "_done"},  {31'd0, a_done},  {31'd0, done});
    endtask

    initial begin
        reset_n = 1'b1;
        a_we = 1'b0; a_cs = 1'b0; a_wa = 2'd0; a_r1 = 2'd0; a_r2 = 2'd0; a_wd = 24'd0;
        b_we = 1'b0; b_cs = 1'b0; b_wa = 5'd0; b_r1 = 5'd0; b_r2 = 5'd0; b_wd = 32'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rd1", {8'd0, a_rd1}, 32'd0);
        chk("rst_rd2", {8'd0, a_rd2}, 32'd0);
        chk_a_flags("rst", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // zero register discards writes and reads 0
        a_we = 1'b1; a_wa = 2'd0; a_wd = 24'hABCDEF; a_r1 = 2'd0;
        tick;
        chk("zero_bypass", {8'd0, a_rd1}, 32'd0);
        a_we = 1'b0;
        tick;
        chk("zero_array", {8'd0, a_rd1}, 32'd0);

        // write then read next cycle
        a_we = 1'b1; a_wa = 2'd2; a_wd = 24'd10; a_r1 = 2'd1;
        tick;
        a_we = 1'b0; a_r1 = 2'd2;
        tick;
        chk("wr_rd_reg2", {8'd0, a_rd1}, 32'd10);

        // same-cycle bypass on both ports
        a_we = 1'b1; a_wa = 2'd3; a_wd = 24'h123456; a_r1 = 2'd3; a_r2 = 2'd3;
        tick;
        chk("bypass_rd1", {8'd0, a_rd1}, 32'h123456);
        chk("bypass_rd2", {8'd0, a_rd2}, 32'h123456);
        a_we = 1'b0;
        tick;
        chk("array_reg3", {8'd0, a_rd1}, 32'h123456);

        // fill regs 1..3 with 5,6,7
        a_we = 1'b1; a_wa = 2'd1; a_wd = 24'd5; tick;
        a_wa = 2'd2; a_wd = 24'd6; tick;
        a_wa = 2'd3; a_wd = 24'd7; tick;
        a_we = 1'b0;

        // sweep: clear_start sampled at t0
        a_r1 = 2'd3; a_r2 = 2'd1; a_cs = 1'b1;
        tick;
        chk_a_flags("t0", 1'b1, 1'b0, 1'b0);
        chk("t0_rd1", {8'd0, a_rd1}, 32'd7);
        chk("t0_rd2", {8'd0, a_rd2}, 32'd5);
        a_we = 1'b1; a_wa = 2'd1; a_wd = 24'h999999;
        tick;
        chk_a_flags("t1", 1'b1, 1'b0, 1'b0);
        chk("t1_rd1", {8'd0, a_rd1}, 32'd7);
        chk("t1_rd2_nobypass", {8'd0, a_rd2}, 32'd5);
        tick;
        chk_a_flags("t2", 1'b1, 1'b0, 1'b0);
        chk("t2_rd1", {8'd0, a_rd1}, 32'd7);
        chk("t2_rd2", {8'd0, a_rd2}, 32'd0);
        tick;
        chk_a_flags("t3", 1'b1, 1'b0, 1'b0);
        chk("t3_rd1", {8'd0, a_rd1}, 32'd7);
        chk("t3_rd2", {8'd0, a_rd2}, 32'd0);
        tick;
        chk_a_flags("t4", 1'b0, 1'b1, 1'b1);
        chk("t4_rd1", {8'd0, a_rd1}, 32'd0);
        // write in DONE is accepted; clear_start still high is ignored
        a_wa = 2'd2; a_wd = 24'h000042; a_r2 = 2'd2;
        tick;
        chk_a_flags("t5", 1'b0, 1'b1, 1'b0);
        chk("t5_done_bypass", {8'd0, a_rd2}, 32'h42);
        a_cs = 1'b0; a_we = 1'b0; a_r1 = 2'd1; a_r2 = 2'd3;
        tick;
        chk_a_flags("t6", 1'b0, 1'b1, 1'b0);
        chk("post_reg1", {8'd0, a_rd1}, 32'd0);
        chk("post_reg3", {8'd0, a_rd2}, 32'd0);
        a_r1 = 2'd2;
        tick;
        chk("post_reg2", {8'd0, a_rd1}, 32'h42);

        // reset mid-sweep
        a_we = 1'b1; a_wa = 2'd1; a_wd = 24'd9; tick;
        a_we = 1'b0; a_r1 = 2'd1; a_cs = 1'b1;
        tick;
        chk("ms_t0_rd1", {8'd0, a_rd1}, 32'd9);
        a_cs = 1'b0;
        tick;
        chk("ms_t1_rd1", {8'd0, a_rd1}, 32'd9);
        chk_a_flags("ms_t1", 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk_a_flags("ms_rst", 1'b0, 1'b1, 1'b0);
        chk("ms_rst_rd1", {8'd0, a_rd1}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (a_done || a_busy) n++;
        end
        chk("ms_no_done", n, 32'd0);
        chk("ms_reg1_zero", {8'd0, a_rd1}, 32'd0);

        // variant: 32-bit, 32 entries, no zero register
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'hDEADBEEF; b_r1 = 5'd0;
        tick;
        chk("b_reg0_bypass", b_rd1, 32'hDEADBEEF);
        b_we = 1'b0;
        tick;
        chk("b_reg0_array", b_rd1, 32'hDEADBEEF);
        b_we = 1'b1; b_wa = 5'd31; b_wd = 32'hCAFEF00D; b_r2 = 5'd0;
        tick;
        b_we = 1'b0; b_r2 = 5'd31;
        tick;
        chk("b_reg31", b_rd2, 32'hCAFEF00D);
        b_cs = 1'b1;
        tick;
        b_cs = 1'b0;
        n = 0;
        while (b_busy && n < 40) begin
            n++;
            tick;
        end
        chk("b_sweep_len", n, 32'd32);
        chk("b_done", {31'd0, b_done}, 32'd1);
        tick;
        chk("b_reg0_clr", b_rd1, 32'd0);
        chk("b_reg31_clr", b_rd2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
